// File: rtl/seven_seg_capture_pkg.sv
// Shared types and constants for the multiplexed seven-segment display capture block.
package seven_seg_capture_pkg;

  localparam int unsigned SEG_W       = 7;
  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned GLYPH_COUNT = 16;
  localparam int unsigned CNT_W       = 4;

  // All segments dark; never a valid glyph.
  localparam logic [SEG_W-1:0] BLANK_PATTERN = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} patterns, indexed by the hex value they show.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [GLYPH_COUNT] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [NIBBLE_W-1:0] nibble;
    logic                err;
  } glyph_t;

endpackage

// File: rtl/seven_seg_capture_glyph_decode.sv
// Combinational segment-pattern to hex-nibble decoder; unknown patterns flag err.
module seg_glyph_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output glyph_t           glyph
);

  always_comb begin
    glyph.nibble = '0;
    glyph.err    = 1'b1;
    for (int unsigned i = 0; i < GLYPH_COUNT; i++) begin
      if (seg_n == GLYPH_TABLE[i]) begin
        glyph.nibble = NIBBLE_W'(i);
        glyph.err    = 1'b0;
      end
    end
    if (seg_n == BLANK_PATTERN) begin
      glyph.nibble = '0;
      glyph.err    = 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a scanned seven-segment display, captures each digit once it is stable,
// and presents complete frames through a valid/ready output register.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SEG_W-1:0]               seg_n,
  input  logic                           dp_n,
  input  logic [NUM_DIGITS-1:0]          digit_n,
  output logic [NUM_DIGITS*NIBBLE_W-1:0] frame_val,
  output logic [NUM_DIGITS-1:0]          frame_dp,
  output logic [NUM_DIGITS-1:0]          frame_err,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overrun
);

  localparam int unsigned SAMPLE_W = NUM_DIGITS + SEG_W + 1;
  localparam int unsigned LOW_W    = $clog2(NUM_DIGITS + 1);

  cap_state_e                 state;
  cap_state_e                 state_next;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_next;
  logic [CNT_W-1:0]           cnt_inc;
  logic [SAMPLE_W-1:0]        sample;
  logic [SAMPLE_W-1:0]        prev;
  logic [LOW_W-1:0]           low_count;
  logic                       strobe;
  logic                       same;
  logic                       stable_hit;
  logic                       capture;
  logic [NUM_DIGITS-1:0]      digit_sel;
  logic [NUM_DIGITS-1:0]      cap_bits;
  logic [NUM_DIGITS-1:0]      mask;
  logic                       frame_done;
  logic                       reg_free;
  logic [NUM_DIGITS*NIBBLE_W-1:0] stage_val;
  logic [NUM_DIGITS-1:0]      stage_dp;
  logic [NUM_DIGITS-1:0]      stage_err;
  glyph_t                     glyph;

  seg_glyph_decode u_decode (
    .seg_n (seg_n),
    .glyph (glyph)
  );

  assign sample     = {digit_n, seg_n, dp_n};
  assign same       = (sample == prev);
  assign cnt_inc    = cnt + CNT_W'(1);
  assign stable_hit = same && (cnt_inc == CNT_W'(STABLE_CYCLES));
  assign digit_sel  = ~digit_n;
  assign cap_bits   = capture ? digit_sel : '0;
  assign frame_done = (mask == '1);
  assign reg_free   = !out_valid || out_ready;

  // A strobe has exactly one digit enable driven low.
  always_comb begin
    low_count = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      low_count = low_count + LOW_W'(digit_sel[k]);
    end
  end
  assign strobe = (low_count == LOW_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (strobe) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!same)           state_next = strobe ? ST_SETTLE : ST_IDLE;
        else if (stable_hit) state_next = ST_HELD;
      end
      ST_HELD: begin
        if (!same) state_next = strobe ? ST_SETTLE : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stability counter update and capture strobe.
  always_comb begin
    cnt_next = cnt;
    capture  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_next = strobe ? CNT_W'(1) : '0;
      end
      ST_SETTLE: begin
        if (same) begin
          cnt_next = cnt_inc;
          capture  = stable_hit;
        end else begin
          cnt_next = strobe ? CNT_W'(1) : '0;
        end
      end
      ST_HELD: begin
        if (!same) cnt_next = strobe ? CNT_W'(1) : '0;
      end
      default: cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // A completed frame frees the mask on the following edge, ready for the next scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else begin
      mask <= (frame_done ? '0 : mask) | cap_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_val <= '0;
      stage_dp  <= '0;
      stage_err <= '0;
    end else if (capture) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (digit_sel[k]) begin
          stage_val[k*NIBBLE_W +: NIBBLE_W] <= glyph.nibble;
          stage_dp[k]                       <= ~dp_n;
          stage_err[k]                      <= glyph.err;
        end
      end
    end
  end

  // Output register: load on completion when free, otherwise drop and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_val <= '0;
      frame_dp  <= '0;
      frame_err <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (frame_done) begin
      if (reg_free) begin
        frame_val <= stage_val;
        frame_dp  <= stage_dp;
        frame_err <= stage_err;
        out_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with a run-length based reference model
// checked every cycle, plus literal expectations at key points.
module tb_seven_seg_capture;

  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic        dp_n = 1'b1;
  logic [3:0]  digit_n = 4'hF;
  logic        out_ready = 1'b0;
  logic [15:0] frame_val;
  logic [3:0]  frame_dp;
  logic [3:0]  frame_err;
  logic        out_valid;
  logic        overrun;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seven_seg_capture #(
    .STABLE_CYCLES (STABLE),
    .NUM_DIGITS    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .digit_n   (digit_n),
    .frame_val (frame_val),
    .frame_dp  (frame_dp),
    .frame_err (frame_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  // Reference model state
  logic [11:0] m_last = '0;
  bit          m_have = 1'b0;
  int          m_run  = 0;
  logic [15:0] m_sval = '0;
  logic [3:0]  m_sdp  = '0;
  logic [3:0]  m_serr = '0;
  logic [3:0]  m_mask = '0;
  logic [15:0] e_val  = '0;
  logic [3:0]  e_dp   = '0;
  logic [3:0]  e_err  = '0;
  logic        e_valid = 1'b0;
  logic        e_ovr   = 1'b0;

  // Returns {err, nibble}
  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    case (s)
      7'h01: return 5'h00;  7'h4F: return 5'h01;  7'h12: return 5'h02;  7'h06: return 5'h03;
      7'h4C: return 5'h04;  7'h24: return 5'h05;  7'h20: return 5'h06;  7'h0F: return 5'h07;
      7'h00: return 5'h08;  7'h04: return 5'h09;  7'h08: return 5'h0A;  7'h60: return 5'h0B;
      7'h31: return 5'h0C;  7'h42: return 5'h0D;  7'h30: return 5'h0E;  7'h38: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  function automatic bit one_low(input logic [3:0] d);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) n++;
    return n == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [11:0] s;
    logic [4:0]  g;
    bit          cap;
    if (!rst_n) begin
      m_have = 1'b0; m_run = 0; m_last = '0;
      m_sval = '0; m_sdp = '0; m_serr = '0; m_mask = '0;
      e_val = '0; e_dp = '0; e_err = '0; e_valid = 1'b0; e_ovr = 1'b0;
    end else begin
      s = {digit_n, seg_n, dp_n};
      if (m_have && s == m_last) m_run++;
      else m_run = 1;
      m_last = s;
      m_have = 1'b1;
      cap = one_low(digit_n) && (m_run == int'(STABLE));
      if (m_mask == 4'hF) begin
        if (!e_valid || out_ready) begin
          e_val = m_sval; e_dp = m_sdp; e_err = m_serr; e_valid = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
        m_mask = '0;
      end else if (e_valid && out_ready) begin
        e_valid = 1'b0;
      end
      if (cap) begin
        g = ref_decode(seg_n);
        for (int k = 0; k < 4; k++) begin
          if (!digit_n[k]) begin
            m_sval[4*k +: 4] = g[3:0];
            m_sdp[k]  = ~dp_n;
            m_serr[k] = g[4];
            m_mask[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({frame_val, frame_dp, frame_err, out_valid, overrun} !==
        {e_val, e_dp, e_err, e_valid, e_ovr}) begin
      fails++;
      $display("FAIL cycle_model t=%0t got val=%h dp=%b err=%b v=%b ovr=%b want val=%h dp=%b err=%b v=%b ovr=%b",
               $time, frame_val, frame_dp, frame_err, out_valid, overrun,
               e_val, e_dp, e_err, e_valid, e_ovr);
    end
  end

  task automatic expect_lit(input string name, input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] err, input logic val, input logic ovr);
    checks++;
    if ({frame_val, frame_dp, frame_err, out_valid, overrun} !== {v, dp, err, val, ovr}) begin
      fails++;
      $display("FAIL %s t=%0t got val=%h dp=%b err=%b v=%b ovr=%b want val=%h dp=%b err=%b v=%b ovr=%b",
               name, $time, frame_val, frame_dp, frame_err, out_valid, overrun,
               v, dp, err, val, ovr);
    end
  endtask

  task automatic drive(input logic [3:0] dn, input logic [6:0] s, input logic d, input int n);
    digit_n = dn;
    seg_n   = s;
    dp_n    = d;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    expect_lit("reset_state", 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // First frame 3,A,F,8 with consumer stalled
    drive(4'hE, 7'h06, 1'b1, 6);
    drive(4'hD, 7'h08, 1'b1, 6);
    drive(4'hB, 7'h38, 1'b1, 6);
    drive(4'h7, 7'h00, 1'b1, 4);
    expect_lit("final_capture_edge", 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h7, 7'h00, 1'b1, 1);
    expect_lit("frame1_valid", 16'h8FA3, 4'h0, 4'h0, 1'b1, 1'b0);
    drive(4'h7, 7'h00, 1'b1, 3);
    expect_lit("frame1_held", 16'h8FA3, 4'h0, 4'h0, 1'b1, 1'b0);
    out_ready = 1'b1;
    drive(4'h7, 7'h00, 1'b1, 1);
    out_ready = 1'b0;
    expect_lit("frame1_consumed", 16'h8FA3, 4'h0, 4'h0, 1'b0, 1'b0);

    // Idle, multi-select, unstable digit 1, blank digit 2
    drive(4'hF, 7'h7F, 1'b1, 2);
    drive(4'hC, 7'h06, 1'b1, 6);
    drive(4'hE, 7'h4F, 1'b0, 6);
    for (int i = 0; i < 3; i++) begin
      drive(4'hD, 7'h08, 1'b1, 2);
      drive(4'hD, 7'h09, 1'b1, 2);
    end
    drive(4'hB, 7'h7F, 1'b1, 6);
    drive(4'h7, 7'h24, 1'b1, 6);
    expect_lit("toggle_no_frame", 16'h8FA3, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(4'hD, 7'h08, 1'b1, 5);
    expect_lit("frame2_blank_err", 16'h50A1, 4'b0001, 4'b0100, 1'b1, 1'b0);

    // Frame completes while output register busy
    drive(4'hE, 7'h20, 1'b1, 6);
    drive(4'hD, 7'h0F, 1'b1, 6);
    drive(4'hB, 7'h00, 1'b1, 6);
    drive(4'h7, 7'h04, 1'b1, 6);
    expect_lit("overrun_drop", 16'h50A1, 4'b0001, 4'b0100, 1'b1, 1'b1);

    // Frame completes with ready asserted in the completion cycle
    drive(4'hE, 7'h60, 1'b1, 6);
    drive(4'hD, 7'h31, 1'b1, 6);
    drive(4'hB, 7'h42, 1'b1, 6);
    drive(4'h7, 7'h30, 1'b1, 4);
    out_ready = 1'b1;
    drive(4'h7, 7'h30, 1'b1, 1);
    out_ready = 1'b0;
    expect_lit("reload_on_ready", 16'hEDCB, 4'h0, 4'h0, 1'b1, 1'b1);

    // Reset mid-settle after three captures
    out_ready = 1'b1;
    drive(4'h7, 7'h30, 1'b1, 1);
    out_ready = 1'b0;
    drive(4'hE, 7'h0F, 1'b1, 6);
    drive(4'hD, 7'h00, 1'b1, 6);
    drive(4'hB, 7'h04, 1'b1, 6);
    drive(4'h7, 7'h08, 1'b1, 2);
    #1 rst_n = 1'b0;
    #1 expect_lit("async_reset", 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    digit_n = 4'hF;
    seg_n   = 7'h7F;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'hD, 7'h12, 1'b1, 6);
    drive(4'hB, 7'h06, 1'b1, 6);
    drive(4'h7, 7'h4C, 1'b1, 6);
    expect_lit("partial_discarded", 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(4'hE, 7'h4F, 1'b1, 5);
    expect_lit("post_reset_frame", 16'h4321, 4'h0, 4'h0, 1'b1, 1'b0);
    drive(4'hF, 7'h7F, 1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
